// File: rtl/alu_issue_stage.sv
// Purpose: decodes a MIPS ALU-class instruction and issues it, with operands, through a single-entry slot.
// Latency: 1 cycle from accept to out_valid; full throughput when accept and consume coincide.
// Backpressure: in_ready drops only while the slot is full and out_ready is low; flush always accepts and discards.
//
// Ports:
//   clk, rst_n              clock and async active-low reset
//   flush                   squash held slot and incoming instruction
//   in_valid/in_ready       upstream handshake for instr, rs_data, rt_data
//   out_valid/out_ready     downstream handshake for the slot outputs
//   alu_A, alu_B, alu_op    ALU operands and operation code
//   wr_reg, wr_en           writeback destination and enable
//   illegal                 held instruction is not ALU-class
//   issue_count             legal instructions consumed downstream (wraps)
module alu_issue_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      alu_A,
    output logic [31:0]      alu_B,
    output logic [3:0]       alu_op,
    output logic [4:0]       wr_reg,
    output logic             wr_en,
    output logic             illegal,
    output logic [CNT_W-1:0] issue_count
);

    // ALU operation codes shared with the execute stage
    localparam logic [3:0] ALU_ADDU = 4'd0;
    localparam logic [3:0] ALU_SUBU = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_LUI  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_NOR  = 4'd11;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // R-type function codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    assign opcode   = instr[31:26];
    assign rt_idx   = instr[20:16];
    assign rd_idx   = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm      = instr[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0000, imm};

    // The rs index is never needed here: the register file has already resolved it into rs_data.
    logic unused_rs_idx;
    assign unused_rs_idx = ^instr[25:21];

    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [3:0]  dec_op;
    logic [4:0]  dec_dst;
    logic        dec_illegal;
    logic        dec_wr_en;

    always_comb begin
        // Defaults describe the illegal-instruction encoding; legal cases override.
        dec_a       = rs_data;
        dec_b       = rt_data;
        dec_op      = ALU_ADDU;
        dec_dst     = 5'd0;
        dec_illegal = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                dec_dst     = rd_idx;
                dec_illegal = 1'b0;
                case (funct)
                    FN_ADDU: dec_op = ALU_ADDU;
                    FN_SUBU: dec_op = ALU_SUBU;
                    FN_AND:  dec_op = ALU_AND;
                    FN_OR:   dec_op = ALU_OR;
                    FN_XOR:  dec_op = ALU_XOR;
                    FN_NOR:  dec_op = ALU_NOR;
                    FN_SLT:  dec_op = ALU_SLT;
                    FN_SLTU: dec_op = ALU_SLTU;
                    FN_SLL: begin dec_op = ALU_SLL; dec_a = {27'd0, shamt}; end
                    FN_SRL: begin dec_op = ALU_SRL; dec_a = {27'd0, shamt}; end
                    FN_SRA: begin dec_op = ALU_SRA; dec_a = {27'd0, shamt}; end
                    FN_SLLV: dec_op = ALU_SLL;
                    FN_SRLV: dec_op = ALU_SRL;
                    FN_SRAV: dec_op = ALU_SRA;
                    default: begin
                        dec_dst     = 5'd0;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDIU: begin dec_op = ALU_ADDU; dec_b = imm_sext; dec_dst = rt_idx; dec_illegal = 1'b0; end
            OP_SLTI:  begin dec_op = ALU_SLT;  dec_b = imm_sext; dec_dst = rt_idx; dec_illegal = 1'b0; end
            // SLTIU sign-extends, then the ALU compares unsigned.
            OP_SLTIU: begin dec_op = ALU_SLTU; dec_b = imm_sext; dec_dst = rt_idx; dec_illegal = 1'b0; end
            OP_ANDI:  begin dec_op = ALU_AND;  dec_b = imm_zext; dec_dst = rt_idx; dec_illegal = 1'b0; end
            OP_ORI:   begin dec_op = ALU_OR;   dec_b = imm_zext; dec_dst = rt_idx; dec_illegal = 1'b0; end
            OP_XORI:  begin dec_op = ALU_XOR;  dec_b = imm_zext; dec_dst = rt_idx; dec_illegal = 1'b0; end
            OP_LUI:   begin dec_op = ALU_LUI;  dec_b = imm_zext; dec_dst = rt_idx; dec_illegal = 1'b0; end
            default: ;
        endcase
    end

    // Writes to $0 are suppressed but the destination still reads 0.
    assign dec_wr_en = ~dec_illegal & (dec_dst != 5'd0);

    logic accept;
    logic consume;

    assign in_ready = flush | ~out_valid | out_ready;
    assign accept   = in_valid & in_ready & ~flush;
    assign consume  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alu_A     <= 32'd0;
            alu_B     <= 32'd0;
            alu_op    <= ALU_ADDU;
            wr_reg    <= 5'd0;
            wr_en     <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            alu_A     <= dec_a;
            alu_B     <= dec_b;
            alu_op    <= dec_op;
            wr_reg    <= dec_dst;
            wr_en     <= dec_wr_en;
            illegal   <= dec_illegal;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

    // A consume coincident with flush has already been seen downstream, so it counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_count <= '0;
        end else if (consume && !illegal) begin
            issue_count <= issue_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Purpose: directed-vector check of alu_issue_stage decode, handshake, flush, reset and counter wrap.
// Latency: expects slot outputs one edge after accept.
// Backpressure: exercises out_ready low with pending input and flush under stall.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [3:0]  alu_op;
    logic [4:0]  wr_reg;
    logic        wr_en;
    logic        illegal;
    logic [15:0] issue_count;

    int n_chk  = 0;
    int n_pass = 0;
    logic [15:0] exp_cnt;

    alu_issue_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
        .wr_reg(wr_reg), .wr_en(wr_en), .illegal(illegal),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic chk_slot(input string t, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [4:0] wr,
                            input logic we, input logic ill);
        chk({t, ".valid"},   64'(out_valid), 64'd1);
        chk({t, ".A"},       64'(alu_A),     64'(a));
        chk({t, ".B"},       64'(alu_B),     64'(b));
        chk({t, ".op"},      64'(alu_op),    64'(op));
        chk({t, ".wr_reg"},  64'(wr_reg),    64'(wr));
        chk({t, ".wr_en"},   64'(wr_en),     64'(we));
        chk({t, ".illegal"}, 64'(illegal),   64'(ill));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single edge, leaving the slot holding it.
    task automatic present(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
        instr    = i;
        rs_data  = rs;
        rt_data  = rt;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = 32'd0; rs_data = 32'd0; rt_data = 32'd0;
        exp_cnt = 16'd0;
        #3;
        chk("rst.valid",   64'(out_valid),   64'd0);
        chk("rst.A",       64'(alu_A),       64'd0);
        chk("rst.B",       64'(alu_B),       64'd0);
        chk("rst.op",      64'(alu_op),      64'd0);
        chk("rst.wr_reg",  64'(wr_reg),      64'd0);
        chk("rst.wr_en",   64'(wr_en),       64'd0);
        chk("rst.illegal", 64'(illegal),     64'd0);
        chk("rst.count",   64'(issue_count), 64'd0);
        chk("rst.in_ready", 64'(in_ready),   64'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // addiu $8,$0,-1
        out_ready = 1'b1;
        present(32'h2408FFFF, 32'd0, 32'd0);
        chk_slot("addiu", 32'd0, 32'hFFFFFFFF, 4'd0, 5'd8, 1'b1, 1'b0);
        chk("addiu.count_before", 64'(issue_count), 64'd0);
        tick();
        exp_cnt = exp_cnt + 16'd1;
        chk("addiu.drained", 64'(out_valid),   64'd0);
        chk("addiu.count",   64'(issue_count), 64'(exp_cnt));

        // Immediate extension and shifts; each consumed on the following edge.
        present(32'h34848000, 32'h11, 32'h0);
        chk_slot("ori", 32'h11, 32'h00008000, 4'd5, 5'd4, 1'b1, 1'b0);
        present(32'h3C051234, 32'h0, 32'h0);
        chk_slot("lui", 32'h0, 32'h00001234, 4'd7, 5'd5, 1'b1, 1'b0);
        present(32'h00031100, 32'hDEAD, 32'h1);
        chk_slot("sll", 32'd4, 32'd1, 4'd8, 5'd2, 1'b1, 1'b0);
        present(32'h2C22FFF0, 32'h5, 32'h0);
        chk_slot("sltiu", 32'h5, 32'hFFFFFFF0, 4'd3, 5'd2, 1'b1, 1'b0);
        present(32'h00A41807, 32'h3, 32'h80000000);
        chk_slot("srav", 32'h3, 32'h80000000, 4'd10, 5'd3, 1'b1, 1'b0);
        tick();
        exp_cnt = exp_cnt + 16'd5;
        chk("imm.count", 64'(issue_count), 64'(exp_cnt));

        // Back-pressure: addu $3,$1,$2 held while subu $4,$2,$3 waits.
        out_ready = 1'b0;
        present(32'h00221821, 32'hA, 32'hB);
        instr = 32'h00432023; rs_data = 32'h20; rt_data = 32'h5; in_valid = 1'b1;
        #1;
        chk("bp.in_ready_low", 64'(in_ready), 64'd0);
        for (int k = 0; k < 5; k++) tick();
        chk_slot("bp.hold", 32'hA, 32'hB, 4'd0, 5'd3, 1'b1, 1'b0);
        chk("bp.count_held", 64'(issue_count), 64'(exp_cnt));
        out_ready = 1'b1;
        #1;
        chk("bp.in_ready_high", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        chk_slot("bp.next", 32'h20, 32'h5, 4'd1, 5'd4, 1'b1, 1'b0);
        tick();
        exp_cnt = exp_cnt + 16'd1;
        chk("bp.count", 64'(issue_count), 64'(exp_cnt));

        // $0 destination and illegal instructions.
        present(32'h00220021, 32'h1, 32'h2);
        chk_slot("zero_dst", 32'h1, 32'h2, 4'd0, 5'd0, 1'b0, 1'b0);
        present(32'h8C000000, 32'h77, 32'h88);
        exp_cnt = exp_cnt + 16'd1;
        chk_slot("lw_illegal", 32'h77, 32'h88, 4'd0, 5'd0, 1'b0, 1'b1);
        present(32'h00A41808, 32'h1, 32'h2);
        chk_slot("funct_illegal", 32'h1, 32'h2, 4'd0, 5'd0, 1'b0, 1'b1);
        tick();
        chk("illegal.count", 64'(issue_count), 64'(exp_cnt));

        // Flush under stall: held and incoming instructions both vanish.
        out_ready = 1'b0;
        present(32'h00221821, 32'h1, 32'h2);
        flush = 1'b1; in_valid = 1'b1; instr = 32'h2408FFFF;
        #1;
        chk("flush.in_ready", 64'(in_ready), 64'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush.valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("flush.not_issued", 64'(out_valid),   64'd0);
        chk("flush.count",      64'(issue_count), 64'(exp_cnt));

        // Consume coincident with flush still counts.
        present(32'h00221821, 32'h1, 32'h2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        chk("flush_consume.count", 64'(issue_count), 64'(exp_cnt));

        // Async reset between edges with the slot full.
        out_ready = 1'b0;
        present(32'h00221821, 32'h1, 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid", 64'(out_valid),   64'd0);
        chk("arst.count", 64'(issue_count), 64'd0);
        chk("arst.A",     64'(alu_A),       64'd0);
        exp_cnt = 16'd0;
        #2;
        rst_n = 1'b1;
        tick();

        // Counter wrap: 65536 edges with input held give 65535 consumes.
        out_ready = 1'b1;
        instr = 32'h2408FFFF; rs_data = 32'd0; in_valid = 1'b1;
        for (int k = 0; k < 65536; k++) tick();
        in_valid = 1'b0;
        chk("wrap.ffff", 64'(issue_count), 64'h0000FFFF);
        tick();
        chk("wrap.zero",  64'(issue_count), 64'h00000000);
        chk("wrap.valid", 64'(out_valid),   64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode-to-execute pipeline stage for the MIPS150 datapath. It is the producer side of the ALU interface.
- Takes a fetched instruction plus register-file read data, decodes the ALU op and operands, and registers them into a single-entry valid/ready pipeline slot.
- The ALU consumes the slot outputs directly.
- Encodings come from the shared ALUop.vh and Opcode.vh definitions.

Parameters:
- CNT_W, 16, width of the issued-instruction counter.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of the held slot and of any incoming instruction.
- in_valid  in  1  instr, rs_data and rt_data are valid this cycle.
- in_ready  out  1  stage accepts the input this cycle.
- instr  in  32  MIPS instruction word.
- rs_data  in  32  register-file value for instr[25:21].
- rt_data  in  32  register-file value for instr[20:16].
- out_valid  out  1  slot holds an issued instruction.
- out_ready  in  1  downstream consumes the slot this cycle.
- alu_A  out  32  ALU operand A.
- alu_B  out  32  ALU operand B.
- alu_op  out  4  ALUop.vh code.
- wr_reg  out  5  destination register.
- wr_en  out  1  result is to be written back.
- illegal  out  1  instruction is not an ALU-class instruction.
- issue_count  out  CNT_W  count of legal instructions consumed downstream.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, alu_A=0, alu_B=0, alu_op=ALU_ADDU, wr_reg=0, wr_en=0, illegal=0, issue_count=0. Reset mid-transfer drops the held instruction.
- Handshake:
  - in_ready = flush | ~out_valid | out_ready (combinational).
  - Accept = in_valid & in_ready & ~flush. Accept loads every slot output on the next edge and sets out_valid=1. Latency 1 cycle.
  - Consume = out_valid & out_ready. If consume occurs without accept, out_valid clears. Back-to-back accept+consume gives full throughput.
  - While out_valid=1 and out_ready=0, all slot outputs hold stable.
  - flush=1: next edge out_valid=0; the held and incoming instructions are both discarded. Flush wins over accept and consume. A consume coincident with flush still counts.
- Decode; opcode = instr[31:26], funct = instr[5:0], imm = instr[15:0]:
  - opcode 0x00, dest rd:
    - ADDU 0x21, SUBU 0x23, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLT 0x2A, SLTU 0x2B: A=rs_data, B=rt_data.
    - SLL 0x00, SRL 0x02, SRA 0x03: A = zero-extended shamt instr[10:6], B=rt_data.
    - SLLV 0x04, SRLV 0x06, SRAV 0x07: A=rs_data, B=rt_data, op SLL/SRL/SRA respectively.
    - Any other funct is illegal.
  - ADDIU 0x09, SLTI 0x0A, SLTIU 0x0B: A=rs_data, B=sign-extended imm; ops ADDU/SLT/SLTU. SLTIU uses the sign-extended immediate, then compares unsigned. Dest rt.
  - ANDI 0x0C, ORI 0x0D, XORI 0x0E: A=rs_data, B=zero-extended imm. Dest rt.
  - LUI 0x0F: A=rs_data, B=zero-extended imm, op ALU_LUI. Dest rt.
  - Any other opcode is illegal.
- Illegal instructions: illegal=1, wr_en=0, op ALU_ADDU, A=rs_data, B=rt_data, wr_reg=0. They still occupy the slot and handshake normally.
- Writes to $0: wr_en=0 whenever the destination is 0; wr_reg still shows 0.
- issue_count: +1 on each consume with illegal=0. Wraps modulo 2^CNT_W with no saturation.

Test Plan:
- Reset, then ADDIU: release rst_n; instr 0x2408FFFF (addiu $8,$0,-1), rs_data=0, in_valid=1, out_ready=1 -> next cycle out_valid=1, alu_A=0, alu_B=0xFFFFFFFF, alu_op=ALU_ADDU, wr_reg=8, wr_en=1; issue_count becomes 1 after consume.
- Immediate extension and shifts:
  - ORI 0x34848000 -> alu_B=0x00008000, dest 4.
  - LUI 0x3C051234 -> alu_B=0x00001234, op ALU_LUI, dest 5.
  - SLL 0x00031100, rt_data=0x1 -> alu_A=4, alu_B=1, op ALU_SLL, dest 2.
- Back-pressure: fill slot with 0x00221821 (addu $3,$1,$2), hold out_ready=0 for 5 cycles with a new in_valid present -> in_ready=0, outputs unchanged; raise out_ready -> new instruction loads the next edge with no gap.
- $0 and illegal:
  - 0x00220021 (addu $0,$1,$2) -> wr_en=0, illegal=0.
  - 0x8C000000 -> illegal=1, wr_en=0, issue_count unchanged after consume.
- Flush: slot full, out_ready=0, flush=1 with in_valid=1 -> next cycle out_valid=0; incoming instruction not issued; in_ready=1 during flush.
- Async reset mid-operation and counter wrap:
  - Assert rst_n low between edges while slot full -> out_valid=0 immediately.
  - Preload issue_count to 0xFFFF via 65535 legal issues, one more -> 0x0000.
